// File: rtl/aes_inv_sbox_pipe.sv
// aes_inv_sbox_pipe: 4-stage AES InvSubBytes over WIDTH/8 bytes, composite-field GF((2^4)^2) inversion.
// GF(16) = GF(2)[x]/(x^4+x+1); GF(256) = GF(16)[y]/(y^2+y+lambda), lambda = x^3+x^2.
module aes_inv_sbox_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int NB = WIDTH / 8;
  localparam int NW = NB * 4;
  localparam logic [3:0] LAM = 4'hC;

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // a^14 is the inverse for nonzero a and maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] map8(input logic [63:0] cols, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r ^= cols[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Composite->AES basis: roots X of x^4+x+1 and Y of y^2+y+lambda(X) found inside AES GF(256)
  function automatic logic [63:0] iso_inv_cols();
    logic [7:0] x, y, t, lam, xp;
    logic [63:0] c;
    x = '0;
    y = '0;
    c = '0;
    for (int v = 255; v >= 2; v--) begin
      t = v[7:0];
      if ((gf8_mul(gf8_mul(t, t), gf8_mul(t, t)) ^ t ^ 8'h01) == 8'h00) x = t;
    end
    lam = gf8_mul(gf8_mul(x, x), x) ^ gf8_mul(x, x);
    for (int v = 255; v >= 1; v--) begin
      t = v[7:0];
      if ((gf8_mul(t, t) ^ t ^ lam) == 8'h00) y = t;
    end
    xp = 8'h01;
    for (int i = 0; i < 4; i++) begin
      c[8*i +: 8] = xp;
      c[8*(i+4) +: 8] = gf8_mul(xp, y);
      xp = gf8_mul(xp, x);
    end
    return c;
  endfunction

  function automatic logic [63:0] invert_cols(input logic [63:0] m);
    logic [63:0] a, b, r;
    logic [7:0] t;
    a = m;
    b = '0;
    for (int i = 0; i < 8; i++) b[8*i + i] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      for (int p = j + 1; p < 8; p++) begin
        if (!a[8*j + j] && a[8*p + j]) begin
          t = a[8*j +: 8]; a[8*j +: 8] = a[8*p +: 8]; a[8*p +: 8] = t;
          t = b[8*j +: 8]; b[8*j +: 8] = b[8*p +: 8]; b[8*p +: 8] = t;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (k != j && a[8*k + j]) begin
          a[8*k +: 8] ^= a[8*j +: 8];
          b[8*k +: 8] ^= b[8*j +: 8];
        end
      end
    end
    r = b;
    return r;
  endfunction

  localparam logic [63:0] INV_ISO = iso_inv_cols();
  localparam logic [63:0] ISO = invert_cols(INV_ISO);

  logic [3:0] v_q, v_d;
  logic [WIDTH-1:0] s1_q, s1_d, s4_q, s4_d;
  logic [NW-1:0] s2_h_q, s2_h_d, s2_l_q, s2_l_d, s2_hl_q, s2_hl_d, s2_hsq_q, s2_hsq_d;
  logic [NW-1:0] s3_h_q, s3_h_d, s3_hl_q, s3_hl_d, s3_di_q, s3_di_d;
  logic en;

  assign en = ~v_q[3] | out_ready;
  assign in_ready = en;
  assign out_valid = v_q[3];
  assign out_data = s4_q;
  assign busy = |v_q;

  always_comb begin
    v_d = en ? {v_q[2:0], in_valid} : v_q;
    s1_d = s1_q;
    s2_h_d = s2_h_q;
    s2_l_d = s2_l_q;
    s2_hl_d = s2_hl_q;
    s2_hsq_d = s2_hsq_q;
    s3_h_d = s3_h_q;
    s3_hl_d = s3_hl_q;
    s3_di_d = s3_di_q;
    s4_d = s4_q;
    for (int k = 0; k < NB; k++) begin
      if (en) begin
        s1_d[8*k +: 8] = map8(ISO, inv_affine(in_data[8*k +: 8]));
        s2_h_d[4*k +: 4] = s1_q[8*k+4 +: 4];
        s2_l_d[4*k +: 4] = s1_q[8*k +: 4];
        s2_hl_d[4*k +: 4] = s1_q[8*k+4 +: 4] ^ s1_q[8*k +: 4];
        s2_hsq_d[4*k +: 4] = gf4_mul(gf4_mul(s1_q[8*k+4 +: 4], s1_q[8*k+4 +: 4]), LAM);
        s3_di_d[4*k +: 4] = gf4_inv(s2_hsq_q[4*k +: 4] ^ gf4_mul(s2_l_q[4*k +: 4], s2_hl_q[4*k +: 4]));
        s3_h_d[4*k +: 4] = s2_h_q[4*k +: 4];
        s3_hl_d[4*k +: 4] = s2_hl_q[4*k +: 4];
        s4_d[8*k +: 8] = map8(INV_ISO, {gf4_mul(s3_h_q[4*k +: 4], s3_di_q[4*k +: 4]),
                                        gf4_mul(s3_hl_q[4*k +: 4], s3_di_q[4*k +: 4])});
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      s1_q <= '0;
      s2_h_q <= '0;
      s2_l_q <= '0;
      s2_hl_q <= '0;
      s2_hsq_q <= '0;
      s3_h_q <= '0;
      s3_hl_q <= '0;
      s3_di_q <= '0;
      s4_q <= '0;
    end else begin
      v_q <= v_d;
      s1_q <= s1_d;
      s2_h_q <= s2_h_d;
      s2_l_q <= s2_l_d;
      s2_hl_q <= s2_hl_d;
      s2_hsq_q <= s2_hsq_d;
      s3_h_q <= s3_h_d;
      s3_hl_q <= s3_hl_d;
      s3_di_q <= s3_di_d;
      s4_q <= s4_d;
    end
  end
endmodule

// File: tb/tb_aes_inv_sbox_pipe.sv
// tb_aes_inv_sbox_pipe: random/directed stimulus against a table model built from plain GF(2^8) arithmetic.
module tb_aes_inv_sbox_pipe;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [15:0] in_data = '0, out_data;
  logic iv32 = 1'b0, ir32, ov32, ob32 = 1'b1, busy32;
  logic [31:0] id32 = '0, od32;
  int n_tests = 0, n_fail = 0, popped = 0;
  logic [7:0] inv_tab [256];
  logic [15:0] sb_q [$];

  aes_inv_sbox_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  aes_inv_sbox_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .out_valid(ov32), .out_ready(ob32), .out_data(od32), .busy(busy32));

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= int'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 32'h11B << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [15:0] ref16(input logic [15:0] w);
    return {inv_tab[w[15:8]], inv_tab[w[7:0]]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy) && t < 30) begin
      step();
      t++;
    end
    check(tag, 32'(sb_q.size()), 0);
  endtask

  // word already presented and accepted on the preceding edge (edge 1)
  task automatic lat_check(input string tag, input logic [15:0] exp);
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'(k == 4));
      check({tag, "_busy"}, 32'(busy), 1);
      if (k < 4) step();
    end
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    step();
    check({tag, "_drain_valid"}, 32'(out_valid), 0);
    check({tag, "_drain_busy"}, 32'(busy), 0);
  endtask

  // scoreboard: every accepted input must come out once, in order
  always @(negedge clk) begin
    if (!rst) sb_q.delete();
    else begin
      if (in_valid && in_ready) sb_q.push_back(ref16(in_data));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_empty", 32'(sb_q.size()), 1);
        else begin
          check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
          popped++;
        end
      end
    end
  end

  initial begin
    logic [7:0] inv, s;
    int gaps, p0, sent, t;
    logic acc, acc_prev;
    logic [15:0] held;
    logic [4:0] pat;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end

    repeat (3) step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_valid32", 32'(ov32), 0);

    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h637C;
    step();
    in_valid = 1'b0;
    lat_check("lat", 16'h0001);

    p0 = popped;
    gaps = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data = {8'(i), 8'(255 - i)};
      step();
      if (i >= 3) begin
        if (!out_valid) gaps++;
        if (i - 3 == 8'h12) check("spot_ED", 32'(out_data[7:0]), 32'h53);
        if (i - 3 == 8'h16) check("spot_16", 32'(out_data[15:8]), 32'hFF);
        if (i - 3 == 8'h00) check("spot_00", 32'(out_data[15:8]), 32'h52);
        if (i - 3 == 8'h9C) check("spot_63", 32'(out_data[7:0]), 32'h00);
      end
    end
    in_valid = 1'b0;
    check("stream_gaps", 32'(gaps), 0);
    drain("stream_drain");
    check("stream_count", 32'(popped - p0), 256);

    p0 = popped;
    sent = 0;
    acc_prev = 1'b1;
    held = '0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 5 && c <= 10);
      if (sent < 6) begin
        if (acc_prev) in_data = 16'($urandom);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (c >= 5 && c <= 10) begin
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        if (c == 5) held = out_data;
        else check("bp_hold", 32'(out_data), 32'(held));
      end
      step();
      if (acc) sent++;
      acc_prev = acc;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    drain("bp_drain");
    check("bp_sent", 32'(sent), 6);
    check("bp_count", 32'(popped - p0), 6);

    pat = 5'b11001;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 5) ? pat[k] : 1'b0;
      in_data = 16'($urandom);
      step();
      check("bubble_valid", 32'(out_valid), (k >= 3 && k < 8) ? 32'(pat[k-3]) : 0);
    end
    in_valid = 1'b0;
    drain("bubble_drain");

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    check("mid_pre_valid", 32'(out_valid), 1);
    check("mid_pre_busy", 32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    step();
    step();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hC5E2;
    step();
    in_valid = 1'b0;
    lat_check("post_rst", 16'h073B);
    drain("post_rst_drain");

    iv32 = 1'b1;
    id32 = 32'h637CED16;
    step();
    iv32 = 1'b0;
    t = 0;
    while (!ov32 && t < 10) begin
      step();
      t++;
    end
    check("w32_valid", 32'(ov32), 1);
    check("w32_latency", 32'(t), 3);
    check("w32_data", od32, 32'h000153FF);

    check("sb_left", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
